instr_encode: RTL

INSTR_ENCODE -- requirements
Module: instr_encode

---
 rtl/rv32_pkg.sv | 53 +++++
 rtl/instr_pack.sv | 107 ++++++++++
 rtl/instr_encode.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the decoders:
// request format codes, major opcodes and the OP-IMM shift funct3 codes.
package rv32_pkg;

    // Request format selector carried on i_fmt
    typedef enum logic [2:0] {
        FMT_LOAD   = 3'd0,
        FMT_STORE  = 3'd1,
        FMT_JAL    = 3'd2,
        FMT_JALR   = 3'd3,
        FMT_BRANCH = 3'd4,
        FMT_LUI    = 3'd5,
        FMT_AUIPC  = 3'd6,
        FMT_OP_IMM = 3'd7
    } fmt_e;

    // Major opcodes, bits [6:0] of every RV32I word
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // OP-IMM funct3 values that carry a shift amount instead of an immediate
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    // Opcode for a request format
    function automatic logic [6:0] fmt_opcode(input fmt_e fmt);
        logic [6:0] op;
        case (fmt)
            FMT_LOAD:   op = OPC_LOAD;
            FMT_STORE:  op = OPC_STORE;
            FMT_JAL:    op = OPC_JAL;
            FMT_JALR:   op = OPC_JALR;
            FMT_BRANCH: op = OPC_BRANCH;
            FMT_LUI:    op = OPC_LUI;
            FMT_AUIPC:  op = OPC_AUIPC;
            FMT_OP_IMM: op = OPC_OP_IMM;
            default:    op = OPC_OP_IMM;
        endcase
        return op;
    endfunction

    // True when an OP-IMM funct3 selects one of the shift instructions
    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == F3_SLLI) || (funct3 == F3_SRXI);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range checker.
// Range checking exists only when INSTR_ENCODE_RANGE_CHECK_EN is defined;
// otherwise range_err is a constant 0 and no check logic is built.
module instr_pack
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_err
);

    fmt_e        fmt_s;
    logic [6:0]  opcode_s;
    logic        shift_s;
    logic [31:0] instr_s;

    assign fmt_s    = fmt_e'(fmt);
    assign opcode_s = fmt_opcode(fmt_s);
    assign shift_s  = is_shift_f3(funct3);

    // Field packing; out-of-range immediates are simply truncated into the fields
    always_comb begin
        instr_s = 32'd0;
        case (fmt_s)
            FMT_LOAD, FMT_JALR: begin
                instr_s = {imm[11:0], rs1, funct3, rd, opcode_s};
            end
            FMT_OP_IMM: begin
                if (shift_s) begin
                    instr_s = {funct7, imm[4:0], rs1, funct3, rd, opcode_s};
                end else begin
                    instr_s = {imm[11:0], rs1, funct3, rd, opcode_s};
                end
            end
            FMT_STORE: begin
                instr_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode_s};
            end
            FMT_BRANCH: begin
                instr_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode_s};
            end
            FMT_JAL: begin
                instr_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode_s};
            end
            FMT_LUI, FMT_AUIPC: begin
                instr_s = {imm[31:12], rd, opcode_s};
            end
            default: begin
                instr_s = {imm[11:0], rs1, funct3, rd, opcode_s};
            end
        endcase
    end

    assign instr = instr_s;

`ifdef INSTR_ENCODE_RANGE_CHECK_EN
    // True when value is representable as a two's-complement number of 'bits' bits
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned bits);
        logic signed [31:0] lo;
        logic signed [31:0] hi;
        lo = -(32'sd1 <<< (bits - 32'd1));
        hi = (32'sd1 <<< (bits - 32'd1)) - 32'sd1;
        return ($signed(value) >= lo) && ($signed(value) <= hi);
    endfunction

    logic range_err_s;

    // Per-format check that the immediate survives packing unchanged
    always_comb begin
        range_err_s = 1'b0;
        case (fmt_s)
            FMT_LOAD, FMT_STORE, FMT_JALR: begin
                range_err_s = !fits_signed(imm, 32'd12);
            end
            FMT_OP_IMM: begin
                if (shift_s) begin
                    range_err_s = (imm[31:5] != 27'd0);
                end else begin
                    range_err_s = !fits_signed(imm, 32'd12);
                end
            end
            FMT_BRANCH: begin
                range_err_s = !fits_signed(imm, 32'd13) || imm[0];
            end
            FMT_JAL: begin
                range_err_s = !fits_signed(imm, 32'd21) || imm[0];
            end
            FMT_LUI, FMT_AUIPC: begin
                range_err_s = (imm[11:0] != 12'd0);
            end
            default: begin
                range_err_s = 1'b0;
            end
        endcase
    end

    assign range_err = range_err_s;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encode.sv
// Two-stage RV32I instruction encoder feeding an instruction-memory loader.
// Stage 1 holds the accepted request, stage 2 holds the packed word, its byte
// address and the range flag. Optional feature macro: INSTR_ENCODE_RANGE_CHECK_EN
// (enables immediate range checking; without it o_range_err is always 0).
module instr_encode
    import rv32_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 32'd0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_fmt,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_range_err
);

    localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(32'd4);

    // Stage 1 request registers
    logic              s1_valid_r;
    logic [2:0]        s1_fmt_r;
    logic [2:0]        s1_funct3_r;
    logic [6:0]        s1_funct7_r;
    logic [4:0]        s1_rd_r;
    logic [4:0]        s1_rs1_r;
    logic [4:0]        s1_rs2_r;
    logic [31:0]       s1_imm_r;

    // Address of the next word to leave the block
    logic [ADDR_W-1:0] addr_cnt_r;

    logic              accept_s;
    logic              xfer_s;
    logic              advance_s;
    logic [ADDR_W-1:0] load_addr_s;
    logic [31:0]       pack_instr_s;
    logic              pack_err_s;

    // Ready stays high through reset so the upstream never sees a stall there
    assign o_ready     = i_rst || !s1_valid_r || !o_valid || i_ready;
    assign accept_s    = i_valid && o_ready;
    assign xfer_s      = o_valid && i_ready;
    assign advance_s   = s1_valid_r && (!o_valid || i_ready);
    // A word entering stage 2 during a transfer follows the departing word
    assign load_addr_s = xfer_s ? (addr_cnt_r + STEP_C) : addr_cnt_r;

    instr_pack u_instr_pack (
        .fmt       (s1_fmt_r),
        .funct3    (s1_funct3_r),
        .funct7    (s1_funct7_r),
        .rd        (s1_rd_r),
        .rs1       (s1_rs1_r),
        .rs2       (s1_rs2_r),
        .imm       (s1_imm_r),
        .instr     (pack_instr_s),
        .range_err (pack_err_s)
    );

    // Stage 1: capture an accepted request, empty when it moves to stage 2
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_r  <= 1'b0;
            s1_fmt_r    <= 3'd0;
            s1_funct3_r <= 3'd0;
            s1_funct7_r <= 7'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_imm_r    <= 32'd0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_fmt_r    <= i_fmt;
            s1_funct3_r <= i_funct3;
            s1_funct7_r <= i_funct7;
            s1_rd_r     <= i_rd;
            s1_rs1_r    <= i_rs1;
            s1_rs2_r    <= i_rs2;
            s1_imm_r    <= i_imm;
        end else if (advance_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2: register packed word; data is frozen while stalled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_instr     <= 32'd0;
            o_addr      <= BASE_C;
            o_range_err <= 1'b0;
        end else if (advance_s) begin
            o_valid     <= 1'b1;
            o_instr     <= pack_instr_s;
            o_addr      <= load_addr_s;
            o_range_err <= pack_err_s;
        end else if (xfer_s) begin
            o_valid     <= 1'b0;
        end else begin
            o_valid     <= o_valid;
        end
    end

    // Address counter: steps by one word per completed output transfer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_cnt_r <= BASE_C;
        end else if (xfer_s) begin
            addr_cnt_r <= addr_cnt_r + STEP_C;
        end else begin
            addr_cnt_r <= addr_cnt_r;
        end
    end

endmodule
